// File: rtl/split_check_sched.sv
// Sequences one candidate through the enabled split checkers in ascending order,
// stops at the first failure or ack timeout, and keeps saturating pass/fail counts.
module split_check_sched #(
    parameter int NUM_SPLITS = 8,
    parameter int SEL_W      = 3,
    parameter int ID_W       = 8,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cand_valid,
    output logic                  cand_ready,
    input  logic [ID_W-1:0]       cand_id,
    input  logic [NUM_SPLITS-1:0] cand_mask,
    output logic                  split_req,
    output logic [SEL_W-1:0]      split_sel,
    input  logic                  split_ack,
    input  logic                  split_ok,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_pass,
    output logic                  res_timeout,
    output logic [SEL_W-1:0]      res_fail_idx,
    output logic [ID_W-1:0]       res_id,
    input  logic                  clear_cnt,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt
);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESULT} state_t;

    state_t                  state_reg;
    logic [NUM_SPLITS-1:0]   mask_reg;
    logic [ID_W-1:0]         id_reg;
    logic [TMR_W-1:0]        timer_reg;

    logic [NUM_SPLITS-1:0]   sel_onehot;
    logic [NUM_SPLITS-1:0]   rest_mask;
    logic [SEL_W-1:0]        cand_lowest;
    logic [SEL_W-1:0]        rest_lowest;
    logic                    finish;
    logic                    fin_pass;
    logic                    fin_timeout;
    logic                    advance;

    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_SPLITS-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SPLITS - 1; i >= 0; i--) begin
            if (m[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    assign cand_ready = (state_reg == IDLE);

    // Splits already passed are cleared from the mask, so the next split is
    // simply the lowest bit still set.
    always_comb begin
        sel_onehot  = NUM_SPLITS'(1) << split_sel;
        rest_mask   = mask_reg & ~sel_onehot;
        cand_lowest = lowest_set(cand_mask);
        rest_lowest = lowest_set(rest_mask);
        finish      = 1'b0;
        fin_pass    = 1'b0;
        fin_timeout = 1'b0;
        advance     = 1'b0;
        if (state_reg == REQ) begin
            if (split_ack) begin
                if (!split_ok) begin
                    finish = 1'b1;
                end else if (|rest_mask) begin
                    advance = 1'b1;
                end else begin
                    finish   = 1'b1;
                    fin_pass = 1'b1;
                end
            end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                finish      = 1'b1;
                fin_timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            mask_reg     <= '0;
            id_reg       <= '0;
            timer_reg    <= '0;
            split_req    <= 1'b0;
            split_sel    <= '0;
            res_valid    <= 1'b0;
            res_pass     <= 1'b0;
            res_timeout  <= 1'b0;
            res_fail_idx <= '0;
            res_id       <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cand_valid) begin
                        id_reg    <= cand_id;
                        mask_reg  <= cand_mask;
                        timer_reg <= '0;
                        if (cand_mask == '0) begin
                            state_reg    <= RESULT;
                            res_valid    <= 1'b1;
                            res_pass     <= 1'b1;
                            res_timeout  <= 1'b0;
                            res_fail_idx <= '0;
                            res_id       <= cand_id;
                        end else begin
                            state_reg <= REQ;
                            split_req <= 1'b1;
                            split_sel <= cand_lowest;
                        end
                    end
                end
                REQ: begin
                    if (finish) begin
                        state_reg    <= RESULT;
                        split_req    <= 1'b0;
                        res_valid    <= 1'b1;
                        res_pass     <= fin_pass;
                        res_timeout  <= fin_timeout;
                        res_fail_idx <= fin_pass ? '0 : split_sel;
                        res_id       <= id_reg;
                    end else if (advance) begin
                        split_sel <= rest_lowest;
                        mask_reg  <= rest_mask;
                        timer_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Clear takes priority over a handshake landing in the same cycle.
            if (clear_cnt) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
            end else if (state_reg == RESULT && res_ready) begin
                if (res_pass) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_split_check_sched.sv
// Directed bench for split_check_sched; counters are narrowed so saturation is reachable quickly.
module tb_split_check_sched;
    localparam int NS = 8;
    localparam int SW = 3;
    localparam int IW = 8;
    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cand_valid;
    logic          cand_ready;
    logic [IW-1:0] cand_id;
    logic [NS-1:0] cand_mask;
    logic          split_req;
    logic [SW-1:0] split_sel;
    logic          split_ack;
    logic          split_ok;
    logic          res_valid;
    logic          res_ready;
    logic          res_pass;
    logic          res_timeout;
    logic [SW-1:0] res_fail_idx;
    logic [IW-1:0] res_id;
    logic          clear_cnt;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;

    int n_cmp = 0;
    int n_err = 0;

    split_check_sched #(
        .NUM_SPLITS(NS), .SEL_W(SW), .ID_W(IW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_id(cand_id), .cand_mask(cand_mask),
        .split_req(split_req), .split_sel(split_sel),
        .split_ack(split_ack), .split_ok(split_ok),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pass(res_pass), .res_timeout(res_timeout),
        .res_fail_idx(res_fail_idx), .res_id(res_id),
        .clear_cnt(clear_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then stable for checking and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; cand_valid = 1'b0; cand_id = '0; cand_mask = '0;
        split_ack = 1'b0; split_ok = 1'b0; res_ready = 1'b0; clear_cnt = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_split_req", split_req, 0);
        chk("rst_split_sel", split_sel, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_cand_ready", cand_ready, 1);

        // All eight splits enabled, every one acked ok immediately.
        cand_valid = 1'b1; cand_id = 8'h5A; cand_mask = 8'hFF;
        split_ack = 1'b1; split_ok = 1'b1;
        tick();
        cand_valid = 1'b0; cand_id = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("all_req_%0d", k), split_req, 1);
            chk($sformatf("all_sel_%0d", k), split_sel, k);
            chk($sformatf("all_nores_%0d", k), res_valid, 0);
            tick();
        end
        chk("all_req_drop", split_req, 0);
        chk("all_res_valid", res_valid, 1);
        chk("all_pass", res_pass, 1);
        chk("all_timeout", res_timeout, 0);
        chk("all_fail_idx", res_fail_idx, 0);
        chk("all_id", res_id, 8'h5A);
        chk("all_cand_ready", cand_ready, 0);
        handshake();
        chk("all_valid_drop", res_valid, 0);
        chk("all_pass_cnt", pass_cnt, 1);
        chk("all_cand_ready_back", cand_ready, 1);

        // Splits 2 and 5 enabled; 2 passes, 5 fails.
        cand_valid = 1'b1; cand_id = 8'h33; cand_mask = 8'b0010_0100;
        tick();
        cand_valid = 1'b0;
        chk("f5_sel_a", split_sel, 2);
        chk("f5_req_a", split_req, 1);
        tick();
        chk("f5_sel_b", split_sel, 5);
        chk("f5_req_b", split_req, 1);
        split_ok = 1'b0;
        tick();
        chk("f5_req_drop", split_req, 0);
        chk("f5_res_valid", res_valid, 1);
        chk("f5_pass", res_pass, 0);
        chk("f5_fail_idx", res_fail_idx, 5);
        chk("f5_timeout", res_timeout, 0);
        chk("f5_id", res_id, 8'h33);
        handshake();
        chk("f5_fail_cnt", fail_cnt, 1);
        chk("f5_pass_cnt", pass_cnt, 1);

        // Split 0 never acks: request must stay high exactly TIMEOUT cycles.
        split_ack = 1'b0;
        cand_valid = 1'b1; cand_id = 8'hC3; cand_mask = 8'h01;
        tick();
        cand_valid = 1'b0;
        cnt = 0;
        while (split_req && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, TO);
        chk("to_res_valid", res_valid, 1);
        chk("to_timeout", res_timeout, 1);
        chk("to_pass", res_pass, 0);
        chk("to_fail_idx", res_fail_idx, 0);
        chk("to_id", res_id, 8'hC3);
        handshake();
        chk("to_fail_cnt", fail_cnt, 2);

        // Empty mask: immediate pass, result held while res_ready is low.
        cand_valid = 1'b1; cand_id = 8'h77; cand_mask = 8'h00;
        tick();
        cand_valid = 1'b0;
        chk("z_split_req", split_req, 0);
        chk("z_res_valid", res_valid, 1);
        chk("z_pass", res_pass, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("z_hold_valid_%0d", k), res_valid, 1);
            chk($sformatf("z_hold_id_%0d", k), res_id, 8'h77);
            chk($sformatf("z_hold_cready_%0d", k), cand_ready, 0);
            chk($sformatf("z_hold_pcnt_%0d", k), pass_cnt, 1);
        end
        handshake();
        chk("z_pass_cnt", pass_cnt, 2);

        // Reset while split 3 is pending.
        cand_valid = 1'b1; cand_id = 8'h11; cand_mask = 8'b0000_1000;
        tick();
        cand_valid = 1'b0;
        chk("r_sel", split_sel, 3);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("r_split_req", split_req, 0);
        chk("r_res_valid", res_valid, 0);
        chk("r_pass_cnt", pass_cnt, 0);
        chk("r_fail_cnt", fail_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        chk("r_cand_ready", cand_ready, 1);
        tick(); tick();
        chk("r_no_result", res_valid, 0);

        // Saturation: 15 passes fill the 4-bit counter, the 16th must not wrap.
        cand_valid = 1'b1; cand_mask = 8'h00; cand_id = 8'hEE; res_ready = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        chk("sat_full", pass_cnt, 15);
        tick(); tick();
        chk("sat_hold", pass_cnt, 15);
        chk("sat_fail_cnt", fail_cnt, 0);
        res_ready = 1'b0;
        tick();
        chk("clr_in_result", res_valid, 1);
        cand_valid = 1'b0;
        clear_cnt = 1'b1; res_ready = 1'b1;
        tick();
        clear_cnt = 1'b0; res_ready = 1'b0;
        chk("clr_pass_cnt", pass_cnt, 0);
        chk("clr_fail_cnt", fail_cnt, 0);
        chk("clr_handshake_done", res_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
